hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the D/E/M pipeline registers and drives the single `stall` signal. That signal freezes PC and IF/ID and flushes ID/EX into a bubble. It keeps its own shadow copy of each in-flight instruction's destination register and Tnew, compares them against the decoded Tuse of the instruction in D, and sequences the multiply/divide unit's busy window.

---
 rtl/mips_defs_pkg.sv | 36 +++
 rtl/md_busy_counter.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 77 +++++++
 tb/tb_hazard_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS hazard logic: Tuse/Tnew encodings,
// the in-flight destination slot, and multiply/divide latency defaults.
package mips_defs;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W        = 4;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{dst: 5'd0, tnew: 2'd0};

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source conflicts with an in-flight slot when the slot writes it and
  // the value will not be ready (or forwardable) by the time it is used.
  function automatic logic src_conflict(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input slot_t      slot);
    return (src != 5'd0) && (tuse != TUSE_NONE) &&
           (slot.dst == src) && (slot.tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy window of the multiply/divide unit, as a down-counter.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   MD_IDLE | cnt == 0; a non-stalled md start loads the latency
//   MD_BUSY | cnt != 0; counts down by one per cycle, HI/LO blocked
//
// The state is not stored separately; it is decoded from cnt so the two
// can never disagree.
module md_busy_counter
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] cnt
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  md_state_e           state;

  // Decode state from the counter and compute the next count.
  always_comb begin
    cnt_d = cnt_q;
    state = (cnt_q != '0) ? MD_BUSY : MD_IDLE;
    case (state)
      MD_IDLE: if (start) cnt_d = is_div ? DIV_LD : MULT_LD;
      MD_BUSY: cnt_d = cnt_q - 1'b1;
      default: cnt_d = '0;
    endcase
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (state == MD_BUSY);
  assign cnt  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall generation for the 5-stage pipeline. Shadows the destination and
// Tnew of the instructions in E and M, compares them with the Tuse of the
// instruction in D, and adds the HI/LO busy window of the md unit.
module hazard_scoreboard
  import mips_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_is_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       md_busy
);

  slot_t e_q, e_d;
  slot_t m_q, m_d;

  logic                haz_rs, haz_rt, haz_md;
  logic                md_load;
  logic [MD_CNT_W-1:0] md_cnt;

  // A start that is stalled stays in D and must not open a busy window.
  assign md_load = d_md_start & ~stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_load),
    .is_div (d_md_is_div),
    .busy   (md_busy),
    .cnt    (md_cnt)
  );

  // Hazard detection from the registered slots and the D-stage fields.
  always_comb begin
    haz_rs = src_conflict(d_rs, d_tuse_rs, e_q) | src_conflict(d_rs, d_tuse_rs, m_q);
    haz_rt = src_conflict(d_rt, d_tuse_rt, e_q) | src_conflict(d_rt, d_tuse_rt, m_q);
    haz_md = d_md_use & md_busy;
    stall  = haz_rs | haz_rt | haz_md;
  end

  // Next slot contents: a stall injects a bubble into E; M ages the E entry.
  always_comb begin
    e_d = SLOT_EMPTY;
    if (!stall) begin
      e_d.dst  = d_dst;
      e_d.tnew = d_tnew;
    end
    m_d.dst  = e_q.dst;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expected stall and
// md_busy values are queued as each D instruction is driven and compared
// against the outputs in the middle of that cycle.
module tb_hazard_scoreboard;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_use;
  logic       stall, md_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic       md_start, md_is_div, md_use;
  } d_in_t;

  typedef struct {
    logic  stall;
    logic  busy;
    string name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_dst       (d_dst),
    .d_tnew      (d_tnew),
    .d_md_start  (d_md_start),
    .d_md_is_div (d_md_is_div),
    .d_md_use    (d_md_use),
    .stall       (stall),
    .md_busy     (md_busy)
  );

  function automatic d_in_t mk(input logic [4:0] rs, input logic [1:0] tuse_rs,
                               input logic [4:0] rt, input logic [1:0] tuse_rt,
                               input logic [4:0] dst, input logic [1:0] tnew,
                               input logic md_start, input logic md_is_div,
                               input logic md_use);
    d_in_t x;
    x.rs = rs; x.tuse_rs = tuse_rs; x.rt = rt; x.tuse_rt = tuse_rt;
    x.dst = dst; x.tnew = tnew;
    x.md_start = md_start; x.md_is_div = md_is_div; x.md_use = md_use;
    return x;
  endfunction

  function automatic d_in_t i_nop();
    return mk(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic d_in_t i_lw(input logic [4:0] dst, input logic [4:0] base);
    return mk(base, 2'd1, 5'd0, TUSE_NONE, dst, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic d_in_t i_md(input logic is_div);
    return mk(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
  endfunction
  function automatic d_in_t i_mflo(input logic [4:0] dst);
    return mk(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, dst, TNEW_ALU, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic drive(input d_in_t x);
    d_rs = x.rs; d_rt = x.rt; d_tuse_rs = x.tuse_rs; d_tuse_rt = x.tuse_rt;
    d_dst = x.dst; d_tnew = x.tnew;
    d_md_start = x.md_start; d_md_is_div = x.md_is_div; d_md_use = x.md_use;
  endtask

  // One pipeline cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic step(input d_in_t x, input logic es, input logic eb, input string nm);
    exp_t e, got;
    drive(x);
    e.stall = es; e.busy = eb; e.name = nm;
    sb_q.push_back(e);
    #3;
    got = sb_q.pop_front();
    checks++;
    if (stall !== got.stall) begin
      errors++;
      $display("FAIL %s stall got %b expected %b at %0t", got.name, stall, got.stall, $time);
    end
    checks++;
    if (md_busy !== got.busy) begin
      errors++;
      $display("FAIL %s md_busy got %b expected %b at %0t", got.name, md_busy, got.busy, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(i_nop(), 1'b0, 1'b0, "idle");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(i_nop());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (dut.e_q !== SLOT_EMPTY || dut.m_q !== SLOT_EMPTY) begin
      errors++;
      $display("FAIL reset_slots got e=%h m=%h expected 0", dut.e_q, dut.m_q);
    end
    step(i_nop(), 1'b0, 1'b0, "reset_outputs");
  endtask

  task automatic test_load_use();
    d_in_t addu = mk(5'd8, TNEW_ALU, 5'd0, TNEW_ALU, 5'd10, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    step(i_lw(5'd8, 5'd29), 1'b0, 1'b0, "lu_lw");
    step(addu, 1'b1, 1'b0, "lu_stall");
    checks++;
    if (dut.e_q !== SLOT_EMPTY) begin
      errors++;
      $display("FAIL lu_bubble e slot got %h expected 0", dut.e_q);
    end
    step(addu, 1'b0, 1'b0, "lu_issue");
    idle(2);
  endtask

  task automatic test_branch();
    d_in_t beq = mk(5'd9, 2'd0, 5'd8, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(i_lw(5'd8, 5'd29), 1'b0, 1'b0, "br_lw");
    step(beq, 1'b1, 1'b0, "br_stall_e");
    step(beq, 1'b1, 1'b0, "br_stall_m");
    step(beq, 1'b0, 1'b0, "br_issue");
    idle(2);
  endtask

  task automatic test_no_hazard();
    d_in_t rd0   = mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd3, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    d_in_t nouse = mk(5'd8, TUSE_NONE, 5'd8, TUSE_NONE, 5'd31, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    d_in_t sw    = mk(5'd29, 2'd1, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(mk(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, TNEW_ALU, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, "nh_addu0");
    step(i_lw(5'd0, 5'd29), 1'b0, 1'b0, "nh_lw0");
    step(rd0, 1'b0, 1'b0, "nh_read0");
    step(i_lw(5'd8, 5'd29), 1'b0, 1'b0, "nh_lw8");
    step(nouse, 1'b0, 1'b0, "nh_tuse3");
    step(i_lw(5'd8, 5'd29), 1'b0, 1'b0, "nh_lw8b");
    step(sw, 1'b0, 1'b0, "nh_store_tuse2");
    idle(2);
  endtask

  task automatic test_md(input logic is_div, input int n);
    step(i_md(is_div), 1'b0, 1'b0, is_div ? "div_start" : "mult_start");
    for (int i = 0; i < n; i++)
      step(i_mflo(5'd2), 1'b1, 1'b1, is_div ? "div_wait" : "mult_wait");
    step(i_mflo(5'd2), 1'b0, 1'b0, is_div ? "div_issue" : "mult_issue");
    idle(1);
  endtask

  task automatic test_back_to_back();
    step(i_md(1'b1), 1'b0, 1'b0, "b2b_div1");
    for (int i = 0; i < 10; i++) step(i_md(1'b1), 1'b1, 1'b1, "b2b_div2_wait");
    step(i_md(1'b1), 1'b0, 1'b0, "b2b_div2_issue");
    for (int i = 0; i < 3; i++) step(i_nop(), 1'b0, 1'b1, "b2b_count");
    checks++;
    if (dut.md_cnt !== 4'd7) begin
      errors++;
      $display("FAIL b2b_cnt got %0d expected 7", dut.md_cnt);
    end
    reset = 1'b1;
    step(i_mflo(5'd2), 1'b1, 1'b1, "rst_during_busy");
    reset = 1'b0;
    checks++;
    if (dut.md_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d expected 0", dut.md_cnt);
    end
    step(i_mflo(5'd2), 1'b0, 1'b0, "rst_after");
    idle(1);
  endtask

  task automatic test_simultaneous();
    d_in_t mfhi = mk(5'd9, 2'd1, 5'd0, TUSE_NONE, 5'd2, TNEW_ALU, 1'b0, 1'b0, 1'b1);
    step(i_md(1'b1), 1'b0, 1'b0, "sim_div");
    step(i_lw(5'd9, 5'd29), 1'b0, 1'b1, "sim_lw");
    // Load clears after one cycle; cnt is 9 here and reaches 0 nine cycles later.
    for (int i = 0; i < 9; i++) step(mfhi, 1'b1, 1'b1, "sim_wait");
    step(mfhi, 1'b0, 1'b0, "sim_issue");
    // Load hazard alone still stalls once the counter is idle.
    step(i_lw(5'd9, 5'd29), 1'b0, 1'b0, "sim_lw2");
    step(mfhi, 1'b1, 1'b0, "sim_load_only");
    step(mfhi, 1'b0, 1'b0, "sim_load_clear");
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_no_hazard();
    test_md(1'b0, 5);
    test_md(1'b1, 10);
    test_back_to_back();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
